// File: rtl/boss_ctrl.sv
// Stage-3 boss sequencer: entry descent, patrol, hurt, dying and dead phases, plus fire-request handshake.
// Optional macro BOSS_CHASE_EN: patrol steers toward player_x - 4 instead of bouncing between bounds.
module boss_ctrl #(
    parameter int X_MIN         = 20,
    parameter int X_MAX         = 290,
    parameter int Y_HOME        = 40,
    parameter int HP_INIT       = 8,
    parameter int ANIM_DIV      = 8,
    parameter int HURT_TICKS    = 16,
    parameter int ATTACK_PERIOD = 60
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic [3:0] i_state,
    input  logic       i_tick,
    input  logic       i_hit,
    input  logic [8:0] i_player_x,
    input  logic       i_fire_ack,
    output logic [8:0] o_boss_x,
    output logic [8:0] o_boss_y,
    output logic [3:0] o_boss_state,
    output logic [3:0] o_hp,
    output logic       o_boss_dead,
    output logic       o_fire_req,
    output logic [8:0] o_fire_x,
    output logic [8:0] o_fire_y
);

    localparam logic [3:0] STAGE3    = 4'd6;
    localparam logic [8:0] XMIN9     = 9'(X_MIN);
    localparam logic [8:0] XMAX9     = 9'(X_MAX);
    localparam logic [8:0] XMID9     = 9'((X_MIN + X_MAX) / 2);
    localparam logic [8:0] YHOME9    = 9'(Y_HOME);
    localparam logic [3:0] HP0       = 4'(HP_INIT);
    // Tick counters are 8 bits wide, so the three periods must stay at or below 256.
    localparam logic [7:0] ANIM_LAST = 8'(ANIM_DIV - 1);
    localparam logic [7:0] HURT_LAST = 8'(HURT_TICKS - 1);
    localparam logic [7:0] ATK_LAST  = 8'(ATTACK_PERIOD - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_ENTER  = 3'd1,
        S_PATROL = 3'd2,
        S_HURT   = 3'd3,
        S_DYING  = 3'd4,
        S_DEAD   = 3'd5
    } fsm_t;

    fsm_t       r_fsm;
    logic [8:0] r_boss_x;
    logic [8:0] r_boss_y;
    logic [3:0] r_boss_state;
    logic [3:0] r_hp;
    logic       r_dir;
    logic [7:0] r_anim_cnt;
    logic [7:0] r_hurt_cnt;
    logic [7:0] r_atk_cnt;
    logic       r_boss_dead;
    logic       r_fire_req;
    logic [8:0] r_fire_x;
    logic [8:0] r_fire_y;

    logic [8:0] w_next_x;
    logic       w_next_dir;
    logic [3:0] w_walk_frame;
    logic [3:0] w_hp_dec;
    logic       w_anim_wrap;

    assign w_walk_frame = {2'b00, r_boss_state[1:0] + 2'd1};
    assign w_anim_wrap  = (r_anim_cnt == ANIM_LAST);
    assign w_hp_dec     = (r_hp == 4'd0) ? 4'd0 : (r_hp - 4'd1);

`ifdef BOSS_CHASE_EN
    logic [8:0] w_target;

    // Chase target: player_x - 4 clamped into the patrol band.
    always_comb begin
        if (i_player_x <= (XMIN9 + 9'd4)) begin
            w_target = XMIN9;
        end else if (i_player_x >= (XMAX9 + 9'd4)) begin
            w_target = XMAX9;
        end else begin
            w_target = i_player_x - 9'd4;
        end
    end

    // One-pixel step toward the target; direction remembers the last actual step.
    always_comb begin
        w_next_x   = r_boss_x;
        w_next_dir = r_dir;
        if (r_boss_x < w_target) begin
            w_next_x   = r_boss_x + 9'd1;
            w_next_dir = 1'b1;
        end else if (r_boss_x > w_target) begin
            w_next_x   = r_boss_x - 9'd1;
            w_next_dir = 1'b0;
        end else begin
            w_next_x   = r_boss_x;
            w_next_dir = r_dir;
        end
    end
`else
    logic w_unused_player;
    assign w_unused_player = ^i_player_x;

    // Bounce patrol: the direction flips on the tick that lands on a bound.
    always_comb begin
        w_next_x   = r_boss_x;
        w_next_dir = r_dir;
        if (r_dir) begin
            if (r_boss_x < XMAX9) begin
                w_next_x = r_boss_x + 9'd1;
            end else begin
                w_next_x = r_boss_x - 9'd1;
            end
        end else begin
            if (r_boss_x > XMIN9) begin
                w_next_x = r_boss_x - 9'd1;
            end else begin
                w_next_x = r_boss_x + 9'd1;
            end
        end
        if (w_next_x > r_boss_x) begin
            w_next_dir = (w_next_x < XMAX9);
        end else begin
            w_next_dir = (w_next_x <= XMIN9);
        end
    end
`endif

    // Boss FSM; leaving STAGE3 is a synchronous abort back to the reset picture.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n || (i_state != STAGE3)) begin
            r_fsm        <= S_IDLE;
            r_boss_x     <= XMID9;
            r_boss_y     <= 9'd0;
            r_boss_state <= 4'd0;
            r_hp         <= HP0;
            r_dir        <= 1'b1;
            r_anim_cnt   <= 8'd0;
            r_hurt_cnt   <= 8'd0;
            r_atk_cnt    <= 8'd0;
            r_boss_dead  <= 1'b0;
            r_fire_req   <= 1'b0;
            r_fire_x     <= 9'd0;
            r_fire_y     <= 9'd0;
        end else begin
            r_boss_dead <= 1'b0;
            // The handshake runs in every phase so a pending request survives leaving PATROL.
            if (r_fire_req && i_fire_ack) begin
                r_fire_req <= 1'b0;
            end
            case (r_fsm)
                S_IDLE: begin
                    r_fsm <= S_ENTER;
                end
                S_ENTER: begin
                    if (i_tick) begin
                        r_boss_y <= r_boss_y + 9'd1;
                        if (w_anim_wrap) begin
                            r_anim_cnt   <= 8'd0;
                            r_boss_state <= w_walk_frame;
                        end else begin
                            r_anim_cnt <= r_anim_cnt + 8'd1;
                        end
                        if ((r_boss_y + 9'd1) == YHOME9) begin
                            r_fsm <= S_PATROL;
                        end
                    end
                end
                S_PATROL: begin
                    if (i_hit) begin
                        r_hp       <= w_hp_dec;
                        r_anim_cnt <= 8'd0;
                        r_hurt_cnt <= 8'd0;
                        if (w_hp_dec == 4'd0) begin
                            r_fsm        <= S_DYING;
                            r_boss_state <= 4'd5;
                        end else begin
                            r_fsm        <= S_HURT;
                            r_boss_state <= 4'd4;
                        end
                    end else if (i_tick) begin
                        r_boss_x <= w_next_x;
                        r_dir    <= w_next_dir;
                        if (w_anim_wrap) begin
                            r_anim_cnt   <= 8'd0;
                            r_boss_state <= w_walk_frame;
                        end else begin
                            r_anim_cnt <= r_anim_cnt + 8'd1;
                        end
                        if (r_atk_cnt == ATK_LAST) begin
                            r_atk_cnt <= 8'd0;
                            if (!r_fire_req) begin
                                r_fire_req <= 1'b1;
                                r_fire_x   <= w_next_x + 9'd4;
                                r_fire_y   <= r_boss_y + 9'd10;
                            end
                        end else begin
                            r_atk_cnt <= r_atk_cnt + 8'd1;
                        end
                    end
                end
                S_HURT: begin
                    if (i_tick) begin
                        if (r_hurt_cnt == HURT_LAST) begin
                            r_fsm        <= S_PATROL;
                            r_boss_state <= 4'd0;
                            r_anim_cnt   <= 8'd0;
                            r_hurt_cnt   <= 8'd0;
                        end else begin
                            r_hurt_cnt <= r_hurt_cnt + 8'd1;
                        end
                    end
                end
                S_DYING: begin
                    if (i_tick) begin
                        if (w_anim_wrap) begin
                            r_anim_cnt <= 8'd0;
                            if (r_boss_state == 4'd7) begin
                                r_fsm       <= S_DEAD;
                                r_boss_dead <= 1'b1;
                            end else begin
                                r_boss_state <= r_boss_state + 4'd1;
                            end
                        end else begin
                            r_anim_cnt <= r_anim_cnt + 8'd1;
                        end
                    end
                end
                S_DEAD: begin
                    r_fsm <= S_DEAD;
                end
                default: begin
                    r_fsm <= S_IDLE;
                end
            endcase
        end
    end

    assign o_boss_x     = r_boss_x;
    assign o_boss_y     = r_boss_y;
    assign o_boss_state = r_boss_state;
    assign o_hp         = r_hp;
    assign o_boss_dead  = r_boss_dead;
    assign o_fire_req   = r_fire_req;
    assign o_fire_x     = r_fire_x;
    assign o_fire_y     = r_fire_y;

endmodule

// File: tb/tb_boss_ctrl.sv
// Self-checking bench for boss_ctrl: behavioural model compared every cycle, plus literal pins.
module tb_boss_ctrl;
    localparam int X_MIN = 20, X_MAX = 290, Y_HOME = 40, HP_INIT = 8;
    localparam int ANIM_DIV = 8, HURT_TICKS = 16, ATTACK_PERIOD = 60;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] st = 4'd0;
    logic       tick = 1'b0, hit = 1'b0, ack = 1'b0;
    logic [8:0] player_x = 9'd100;
    logic [8:0] boss_x, boss_y, fire_x, fire_y;
    logic [3:0] boss_state, hp;
    logic       boss_dead, fire_req;

    always #5 clk = ~clk;

    boss_ctrl dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_state(st), .i_tick(tick), .i_hit(hit),
        .i_player_x(player_x), .i_fire_ack(ack),
        .o_boss_x(boss_x), .o_boss_y(boss_y), .o_boss_state(boss_state), .o_hp(hp),
        .o_boss_dead(boss_dead), .o_fire_req(fire_req), .o_fire_x(fire_x), .o_fire_y(fire_y)
    );

    // Model: mode 0 idle, 1 enter, 2 patrol, 3 hurt, 4 dying, 5 dead; tick tallies drive the frames.
    int m_mode, m_x, m_y, m_hp, m_dir, m_walk, m_pat, m_hurt, m_die, m_fx, m_fy;
    bit m_dead, m_req;
    int n_checks = 0, n_errs = 0, dead_seen = 0, cyc_no = 0;

    function automatic int m_frame();
        case (m_mode)
            3:       return 4;
            4:       return 5 + m_die / ANIM_DIV;
            5:       return 7;
            default: return (m_walk / ANIM_DIV) % 4;
        endcase
    endfunction

    task automatic model_reset();
        m_mode = 0; m_x = (X_MIN + X_MAX) / 2; m_y = 0; m_hp = HP_INIT; m_dir = 1;
        m_walk = 0; m_pat = 0; m_hurt = 0; m_die = 0; m_fx = 0; m_fy = 0;
        m_dead = 1'b0; m_req = 1'b0;
    endtask

    task automatic model_step(input bit t, input bit h, input bit a);
        bit old_req;
        if (!rst_n || st != 4'd6) begin
            model_reset();
        end else begin
            old_req = m_req;
            m_dead = 1'b0;
            if (m_req && a) m_req = 1'b0;
            case (m_mode)
                0: m_mode = 1;
                1: if (t) begin
                    m_y++; m_walk++;
                    if (m_y == Y_HOME) m_mode = 2;
                end
                2: if (h) begin
                    if (m_hp > 0) m_hp--;
                    if (m_hp == 0) begin m_mode = 4; m_die = 0; end
                    else begin m_mode = 3; m_hurt = 0; end
                end else if (t) begin
                    m_x += m_dir;
                    if (m_x >= X_MAX) m_dir = -1;
                    else if (m_x <= X_MIN) m_dir = 1;
                    m_walk++; m_pat++;
                    if (m_pat % ATTACK_PERIOD == 0 && !old_req) begin
                        m_req = 1'b1; m_fx = m_x + 4; m_fy = m_y + 10;
                    end
                end
                3: if (t) begin
                    m_hurt++;
                    if (m_hurt == HURT_TICKS) begin m_mode = 2; m_walk = 0; end
                end
                4: if (t) begin
                    m_die++;
                    if (m_die == 3 * ANIM_DIV) begin m_mode = 5; m_dead = 1'b1; end
                end
                default: ;
            endcase
        end
    endtask

    task automatic compare();
        n_checks++;
        if (int'(boss_x) != m_x || int'(boss_y) != m_y || int'(boss_state) != m_frame() ||
            int'(hp) != m_hp || boss_dead != m_dead || fire_req != m_req ||
            int'(fire_x) != m_fx || int'(fire_y) != m_fy) begin
            n_errs++;
            $display("FAIL cycle %0d (dut/model): x=%0d/%0d y=%0d/%0d frame=%0d/%0d hp=%0d/%0d dead=%0d/%0d req=%0d/%0d fx=%0d/%0d fy=%0d/%0d",
                     cyc_no, boss_x, m_x, boss_y, m_y, boss_state, m_frame(), hp, m_hp,
                     boss_dead, m_dead, fire_req, m_req, fire_x, m_fx, fire_y, m_fy);
        end
        if (boss_dead) dead_seen++;
    endtask

    task automatic lit(input string nm, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errs++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic cyc(input bit t, input bit h, input bit a);
        tick = t; hit = h; ack = a;
        model_step(t, h, a);
        @(posedge clk);
        #1;
        cyc_no++;
        compare();
        tick = 1'b0; hit = 1'b0; ack = 1'b0;
    endtask

    task automatic tk();
        int gap;
        gap = $urandom_range(0, 2);
        repeat (gap) cyc(1'b0, 1'b0, 1'b0);
        cyc(1'b1, 1'b0, 1'b0);
    endtask

    initial begin
        rst_n = 1'b0; st = 4'd0;
        repeat (3) cyc(1'b0, 1'b0, 1'b0);
        lit("reset_x", int'(boss_x), 155);
        lit("reset_y", int'(boss_y), 0);
        lit("reset_hp", int'(hp), 8);
        lit("reset_frame", int'(boss_state), 0);
        lit("reset_req", int'(fire_req), 0);

        rst_n = 1'b1; st = 4'd6;
        cyc(1'b0, 1'b0, 1'b0);
        repeat (40) tk();
        lit("enter_y", int'(boss_y), 40);
        lit("enter_x", int'(boss_x), 155);

        for (int k = 1; k <= 160; k++) begin
            tk();
            if (k == 60) begin
                lit("fire_req_rise", int'(fire_req), 1);
                lit("fire_x", int'(fire_x), 219);
                lit("fire_y", int'(fire_y), 50);
            end
            if (k == 135) lit("bound_x", int'(boss_x), 290);
            if (k == 136) lit("bounce_x", int'(boss_x), 289);
        end
        lit("req_held", int'(fire_req), 1);
        lit("fire_x_held", int'(fire_x), 219);
        cyc(1'b0, 1'b0, 1'b1);
        lit("req_drop", int'(fire_req), 0);

        cyc(1'b0, 1'b1, 1'b0);
        lit("hit_hp", int'(hp), 7);
        lit("hurt_frame", int'(boss_state), 4);
        for (int j = 1; j <= 16; j++) begin
            tk();
            if (j == 5) begin
                cyc(1'b0, 1'b1, 1'b0);
                lit("hurt_invuln_hp", int'(hp), 7);
            end
            if (j == 15) lit("hurt_still", int'(boss_state), 4);
            if (j == 16) lit("walk_resume", int'(boss_state), 0);
        end

        for (int h = 2; h <= 8; h++) begin
            repeat ($urandom_range(1, 5)) tk();
            cyc(1'b0, 1'b1, 1'b0);
            if (h < 8) repeat (16) tk();
        end
        lit("dying_hp", int'(hp), 0);
        lit("dying_frame5", int'(boss_state), 5);
        dead_seen = 0;
        for (int d = 1; d <= 24; d++) begin
            tk();
            if (d == 8) lit("dying_frame6", int'(boss_state), 6);
            if (d == 24) begin
                lit("dead_pulse", int'(boss_dead), 1);
                lit("dead_frame", int'(boss_state), 7);
            end
        end
        repeat (10) tk();
        lit("dead_once", dead_seen, 1);
        lit("dead_hp", int'(hp), 0);

        st = 4'd8; cyc(1'b0, 1'b0, 1'b0);
        st = 4'd6; cyc(1'b0, 1'b0, 1'b0);
        repeat (110) tk();
        lit("abort_pre_req", int'(fire_req), 1);
        st = 4'd8; cyc(1'b0, 1'b0, 1'b0);
        lit("abort_x", int'(boss_x), 155);
        lit("abort_y", int'(boss_y), 0);
        lit("abort_hp", int'(hp), 8);
        lit("abort_req", int'(fire_req), 0);
        lit("abort_frame", int'(boss_state), 0);

        st = 4'd6;
        for (int c = 0; c < 5000; c++) begin
            if ($urandom_range(0, 1499) == 0) st = 4'($urandom_range(0, 15));
            else if (st != 4'd6 && $urandom_range(0, 3) == 0) st = 4'd6;
            rst_n = ($urandom_range(0, 1999) != 0);
            cyc(bit'($urandom_range(0, 1)), ($urandom_range(0, 19) == 0), ($urandom_range(0, 7) == 0));
        end

        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end
endmodule

// File: doc/boss_ctrl.md
Name: boss_ctrl

Overview:
- Sequences the stage-3 boss sprite: position (boss_x, boss_y), animation frame index (boss_state), hit points, death, and projectile spawn requests.
- Feeds the combinational boss sprite renderer, which draws a 10x10 sprite at (boss_x, boss_y) in 320x240 half-resolution coordinates and selects frame column boss_state.
- Advances only on the one-cycle video-frame tick while the game state is STAGE3.

Parameters:
- X_MIN, 20, left patrol bound (pixels).
- X_MAX, 290, right patrol bound, inclusive; must be ≤ 310.
- Y_HOME, 40, patrol row reached after the entry descent.
- HP_INIT, 8, starting hit points (1..15).
- ANIM_DIV, 8, ticks per walk-animation frame.
- HURT_TICKS, 16, ticks spent in HURT.
- ATTACK_PERIOD, 60, PATROL ticks between fire requests.

Ports:
- clk  in  1  system clock
- rst_n  in  1  synchronous active-low reset
- state  in  4  game state; STAGE3 = 6
- tick  in  1  one-cycle pulse per video frame
- hit  in  1  one-cycle pulse, player shot collided with boss
- player_x  in  9  player x, used only with BOSS_CHASE_EN
- fire_ack  in  1  projectile unit accepted fire request
- boss_x  out  9  sprite left column
- boss_y  out  9  sprite top row
- boss_state  out  4  frame index: 0-3 walk, 4 hurt, 5-7 dying
- hp  out  4  remaining hit points
- boss_dead  out  1  one-cycle pulse on entering DEAD
- fire_req  out  1  projectile spawn request
- fire_x  out  9  spawn x = boss_x+4, latched on assert
- fire_y  out  9  spawn y = boss_y+10, latched on assert

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - FSM to IDLE.
  - boss_x=(X_MIN+X_MAX)/2, boss_y=0, boss_state=0, hp=HP_INIT, dir=right.
  - All counters 0.
  - boss_dead=0, fire_req=0, fire_x=0, fire_y=0.
- Stage gating: state≠STAGE3 in any FSM state → next cycle takes the reset values above; this is a synchronous abort. A subsequent STAGE3 restarts from IDLE.
- FSM states: IDLE, ENTER, PATROL, HURT, DYING, DEAD.
- IDLE:
  - If state==STAGE3 → ENTER on the next clk. No tick is needed.
- ENTER:
  - Each tick: boss_y+=1; boss_state cycles 0-3 every ANIM_DIV ticks.
  - boss_y reaches Y_HOME → PATROL.
  - hit is ignored.
- PATROL:
  - Each tick: boss_x moves 1 px in dir.
  - At the boss_x==X_MAX tick, dir flips to left; at X_MIN it flips to right. boss_x never leaves [X_MIN, X_MAX].
  - Walk frames 0→1→2→3→0, advancing every ANIM_DIV ticks.
  - attack counter increments per tick. At ATTACK_PERIOD−1 it clears; fire_req asserts if it is not already high.
- Fire handshake:
  - fire_req, fire_x and fire_y are held stable until a cycle with fire_ack=1. fire_req drops in the following cycle.
  - A new period expiring while fire_req is high is dropped, not queued.
  - Leaving PATROL does not cancel a pending request.
  - fire_ack with fire_req=0 is ignored.
- hit in PATROL:
  - hp decrements, saturating at 0.
  - If the new hp==0 → DYING; otherwise → HURT.
  - The decision uses the post-decrement value in the same cycle.
- HURT:
  - boss_state=4; position frozen; hit ignored (invulnerable); attack counter paused.
  - After HURT_TICKS ticks → PATROL. The walk frame resumes at 0.
- DYING:
  - boss_state steps 5→6→7, one step every ANIM_DIV ticks.
  - After ANIM_DIV ticks spent on frame 7 → DEAD.
- DEAD:
  - boss_dead=1 for exactly the entry cycle.
  - Outputs hold, with boss_state=7.
  - Remains in DEAD until state≠STAGE3.
- Simultaneous events:
  - hit and tick in the same PATROL cycle: the hit transition wins and no move is applied.
  - hit and fire_ack together: both are honoured.
- Widths: boss_x/boss_y are 9-bit unsigned. fire_x/fire_y are computed in 9 bits; overflow cannot occur within the parameter limits.

Optional Feature:
- Macro: BOSS_CHASE_EN.
- Defined: in PATROL, each tick, boss_x steps 1 px toward player_x−4, clamped to [X_MIN, X_MAX]. boss_x holds when equal. dir tracks the last step direction.
- Undefined: bounce patrol as above; player_x is unused.

Test Plan:
- Reset, then state=6 with ticks → ENTER. boss_y reaches 40 after 40 ticks, boss_x stays 155, then PATROL.
- PATROL with 135 ticks from x=155 → boss_x=290 and dir flips. The next tick gives 289.
- 60 PATROL ticks → fire_req=1 with fire_x=boss_x+4 and fire_y=50. Hold fire_ack=0 for 100 ticks → one request stays stable, no second request. Pulse ack → req=0 next cycle.
- hit in PATROL → hp 8→7, boss_state=4 for 16 ticks, second hit during HURT ignored → hp stays 7.
- 8 hits, each spaced after HURT → DYING frames 5,6,7 with 8 ticks each. boss_dead pulses once; hp=0.
- Mid-PATROL, state switches to 8 → next cycle boss_x=155, boss_y=0, hp=8, fire_req=0, FSM in IDLE.
